led_mode_ctrl: RTL and testbench

LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

---
 rtl/led_mode_ctrl.sv | 112 +++++++++++
 tb/tb_led_mode_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_mode_ctrl.sv
// LED mode controller: OFF / BLINK / CHASE / COUNT patterns on four LEDs,
// stepped once per TICK_CYCLES clocks, with a pause input and mode advance.
// Ports: i_Clk, i_Rst (sync, active-high), i_Next (advance), i_Pause (hold),
//        o_Mode[1:0], o_LED_1..o_LED_4 (registered pattern bits 0..3).
// Config: define LED_MODE_CTRL_EDGE_DETECT_EN to treat i_Next as a level and
//         advance only on its rising edge; otherwise every high cycle advances.
module led_mode_ctrl #(
   parameter int TICK_CYCLES = 12_500_000
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic       i_Next,
   input  logic       i_Pause,
   output logic [1:0] o_Mode,
   output logic       o_LED_1,
   output logic       o_LED_2,
   output logic       o_LED_3,
   output logic       o_LED_4
);

   localparam int CW = $clog2(TICK_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(TICK_CYCLES - 1);

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_BLINK = 2'd1,
      MODE_CHASE = 2'd2,
      MODE_COUNT = 2'd3
   } mode_e;

   mode_e          mode_q, mode_d;
   logic [3:0]     pat_q, pat_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           adv;
   logic           tick;

`ifdef LED_MODE_CTRL_EDGE_DETECT_EN
   logic next_q;

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         next_q <= 1'b0;
      end else begin
         next_q <= i_Next;
      end
   end

   assign adv = i_Next & ~next_q;
`else
   assign adv = i_Next;
`endif

   // A paused counter never reaches its tick
   assign tick = ~i_Pause & (cnt_q == CNT_MAX);

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         mode_q <= MODE_OFF;
         pat_q  <= 4'b0000;
         cnt_q  <= '0;
      end else begin
         mode_q <= mode_d;
         pat_q  <= pat_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      mode_d = mode_q;
      pat_d  = pat_q;
      cnt_d  = cnt_q;
      if (adv) begin
         // Advance beats pause and tick: new mode, entry pattern, fresh count
         cnt_d = '0;
         unique case (mode_q)
            MODE_OFF: begin
               mode_d = MODE_BLINK;
               pat_d  = 4'b0000;
            end
            MODE_BLINK: begin
               mode_d = MODE_CHASE;
               pat_d  = 4'b0001;
            end
            MODE_CHASE: begin
               mode_d = MODE_COUNT;
               pat_d  = 4'b0000;
            end
            MODE_COUNT: begin
               mode_d = MODE_OFF;
               pat_d  = 4'b0000;
            end
         endcase
      end else if (!i_Pause) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
         if (tick) begin
            unique case (mode_q)
               MODE_OFF:   pat_d = 4'b0000;
               MODE_BLINK: pat_d = ~pat_q;
               MODE_CHASE: pat_d = {pat_q[2:0], pat_q[3]};
               MODE_COUNT: pat_d = pat_q + 4'd1;
            endcase
         end
      end
   end

   assign o_Mode  = mode_q;
   assign o_LED_1 = pat_q[0];
   assign o_LED_2 = pat_q[1];
   assign o_LED_3 = pat_q[2];
   assign o_LED_4 = pat_q[3];

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed testbench for led_mode_ctrl with TICK_CYCLES=50.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_led_mode_ctrl;

   localparam int TC = 50;

   logic       clk;
   logic       rst;
   logic       nxt;
   logic       pause;
   logic [1:0] mode;
   logic       l1, l2, l3, l4;
   logic [3:0] leds;

   int nvec = 0;
   int nerr = 0;

   assign leds = {l4, l3, l2, l1};

   led_mode_ctrl #(.TICK_CYCLES(TC)) dut (
      .i_Clk   (clk),
      .i_Rst   (rst),
      .i_Next  (nxt),
      .i_Pause (pause),
      .o_Mode  (mode),
      .o_LED_1 (l1),
      .o_LED_2 (l2),
      .o_LED_3 (l3),
      .o_LED_4 (l4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_next();
      nxt = 1'b1;
      step(1);
      nxt = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      nxt = 1'b0;
      pause = 1'b0;
      step(2);
      nvec++;
      if (mode !== 2'd0 || leds !== 4'b0000) begin
         nerr++;
         $display("FAIL reset: mode=%0d leds=%b want mode=0 leds=0000",
                  mode, leds);
      end
      rst = 1'b0;
      for (int i = 0; i < 200; i++) begin
         step(1);
         nvec++;
         if (mode !== 2'd0 || leds !== 4'b0000) begin
            nerr++;
            $display("FAIL idle[%0d]: mode=%0d leds=%b want 0/0000",
                     i, mode, leds);
         end
      end
   endtask

   task automatic test_blink();
      pulse_next();
      nvec++;
      if (mode !== 2'd1 || leds !== 4'b0000) begin
         nerr++;
         $display("FAIL blink_entry: mode=%0d leds=%b want 1/0000",
                  mode, leds);
      end
      step(TC - 1);
      nvec++;
      if (leds !== 4'b0000) begin
         nerr++;
         $display("FAIL blink_pre1: leds=%b want 0000", leds);
      end
      step(1);
      nvec++;
      if (leds !== 4'b1111) begin
         nerr++;
         $display("FAIL blink_tick1: leds=%b want 1111", leds);
      end
      step(TC - 1);
      nvec++;
      if (leds !== 4'b1111) begin
         nerr++;
         $display("FAIL blink_pre2: leds=%b want 1111", leds);
      end
      step(1);
      nvec++;
      if (leds !== 4'b0000) begin
         nerr++;
         $display("FAIL blink_tick2: leds=%b want 0000", leds);
      end
   endtask

   task automatic test_chase();
      logic [3:0] seq [4];
      logic [3:0] prev;
      seq[0] = 4'b0010;
      seq[1] = 4'b0100;
      seq[2] = 4'b1000;
      seq[3] = 4'b0001;
      pulse_next();
      nvec++;
      if (mode !== 2'd2 || leds !== 4'b0001) begin
         nerr++;
         $display("FAIL chase_entry: mode=%0d leds=%b want 2/0001",
                  mode, leds);
      end
      prev = 4'b0001;
      for (int k = 0; k < 4; k++) begin
         step(TC - 1);
         nvec++;
         if (leds !== prev) begin
            nerr++;
            $display("FAIL chase_hold[%0d]: leds=%b want %b", k, leds, prev);
         end
         step(1);
         nvec++;
         if (leds !== seq[k]) begin
            nerr++;
            $display("FAIL chase_tick[%0d]: leds=%b want %b",
                     k, leds, seq[k]);
         end
         prev = seq[k];
      end
   endtask

   task automatic test_count_pause();
      logic [3:0] exp;
      pulse_next();
      nvec++;
      if (mode !== 2'd3 || leds !== 4'b0000) begin
         nerr++;
         $display("FAIL count_entry: mode=%0d leds=%b want 3/0000",
                  mode, leds);
      end
      step(TC);
      step(TC);
      nvec++;
      if (leds !== 4'b0010) begin
         nerr++;
         $display("FAIL count_2: leds=%b want 0010", leds);
      end
      step(20);
      pause = 1'b1;
      for (int i = 0; i < 300; i++) begin
         step(1);
         nvec++;
         if (mode !== 2'd3 || leds !== 4'b0010) begin
            nerr++;
            $display("FAIL count_paused[%0d]: mode=%0d leds=%b want 3/0010",
                     i, mode, leds);
         end
      end
      pause = 1'b0;
      step(29);
      nvec++;
      if (leds !== 4'b0010) begin
         nerr++;
         $display("FAIL count_resume_hold: leds=%b want 0010", leds);
      end
      step(1);
      nvec++;
      if (leds !== 4'b0011) begin
         nerr++;
         $display("FAIL count_resume_tick: leds=%b want 0011", leds);
      end
      for (int k = 4; k <= 16; k++) begin
         step(TC);
         exp = 4'(k);
         nvec++;
         if (leds !== exp) begin
            nerr++;
            $display("FAIL count_tick[%0d]: leds=%b want %b", k, leds, exp);
         end
      end
   endtask

   task automatic test_tick_advance();
      pulse_next();
      step(1);
      pulse_next();
      nvec++;
      if (mode !== 2'd1 || leds !== 4'b0000) begin
         nerr++;
         $display("FAIL ta_blink: mode=%0d leds=%b want 1/0000", mode, leds);
      end
      step(TC - 1);
      nxt = 1'b1;
      step(1);
      nxt = 1'b0;
      nvec++;
      if (mode !== 2'd2 || leds !== 4'b0001) begin
         nerr++;
         $display("FAIL ta_collide: mode=%0d leds=%b want 2/0001",
                  mode, leds);
      end
      step(TC - 1);
      nvec++;
      if (leds !== 4'b0001) begin
         nerr++;
         $display("FAIL ta_hold: leds=%b want 0001", leds);
      end
      step(1);
      nvec++;
      if (leds !== 4'b0010) begin
         nerr++;
         $display("FAIL ta_first_tick: leds=%b want 0010", leds);
      end
   endtask

   task automatic test_pause_advance();
      pause = 1'b1;
      nxt = 1'b1;
      step(1);
      nxt = 1'b0;
      nvec++;
      if (mode !== 2'd3 || leds !== 4'b0000) begin
         nerr++;
         $display("FAIL pa_same: mode=%0d leds=%b want 3/0000", mode, leds);
      end
      step(100);
      nvec++;
      if (mode !== 2'd3 || leds !== 4'b0000) begin
         nerr++;
         $display("FAIL pa_held: mode=%0d leds=%b want 3/0000", mode, leds);
      end
      pause = 1'b0;
      step(TC - 1);
      nvec++;
      if (leds !== 4'b0000) begin
         nerr++;
         $display("FAIL pa_release_hold: leds=%b want 0000", leds);
      end
      step(1);
      nvec++;
      if (leds !== 4'b0001) begin
         nerr++;
         $display("FAIL pa_release_tick: leds=%b want 0001", leds);
      end
      pause = 1'b1;
      step(5);
      pulse_next();
      step(1);
      pulse_next();
      step(1);
      pulse_next();
      nvec++;
      if (mode !== 2'd2 || leds !== 4'b0001) begin
         nerr++;
         $display("FAIL pa_paused_adv: mode=%0d leds=%b want 2/0001",
                  mode, leds);
      end
      step(100);
      nvec++;
      if (mode !== 2'd2 || leds !== 4'b0001) begin
         nerr++;
         $display("FAIL pa_paused_hold: mode=%0d leds=%b want 2/0001",
                  mode, leds);
      end
      pause = 1'b0;
   endtask

   task automatic test_reset_mid();
      step(1);
      pulse_next();
      step(TC + 10);
      nvec++;
      if (mode !== 2'd3 || leds !== 4'b0001) begin
         nerr++;
         $display("FAIL rm_count: mode=%0d leds=%b want 3/0001", mode, leds);
      end
      rst = 1'b1;
      nxt = 1'b1;
      step(1);
      nvec++;
      if (mode !== 2'd0 || leds !== 4'b0000) begin
         nerr++;
         $display("FAIL rm_reset: mode=%0d leds=%b want 0/0000", mode, leds);
      end
      rst = 1'b0;
      nxt = 1'b0;
      step(1);
      nvec++;
      if (mode !== 2'd0 || leds !== 4'b0000) begin
         nerr++;
         $display("FAIL rm_after: mode=%0d leds=%b want 0/0000", mode, leds);
      end
   endtask

   task automatic test_held_next();
      logic [1:0] exp;
      nxt = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         step(1);
`ifdef LED_MODE_CTRL_EDGE_DETECT_EN
         exp = 2'd1;
`else
         exp = 2'(k % 4);
`endif
         nvec++;
         if (mode !== exp) begin
            nerr++;
            $display("FAIL held[%0d]: mode=%0d want %0d", k, mode, exp);
         end
      end
      nxt = 1'b0;
      step(1);
`ifdef LED_MODE_CTRL_EDGE_DETECT_EN
      exp = 2'd1;
`else
      exp = 2'd2;
`endif
      nvec++;
      if (mode !== exp) begin
         nerr++;
         $display("FAIL held_final: mode=%0d want %0d", mode, exp);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: sim time exceeded");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      nxt = 1'b0;
      pause = 1'b0;
      test_reset();
      test_blink();
      test_chase();
      test_count_pause();
      test_tick_advance();
      test_pause_advance();
      test_reset_mid();
      test_held_next();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
